// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared types and constants for the count_ctrl sequencer.
//   state_e        - sequencer states (IDLE, RUN, HOLD, DONE)
//   MODE_ONESHOT   - run once up to the limit, then pulse done
//   MODE_PERIODIC  - auto-reload to 0 after each terminal step
//   is_busy()      - true for the states that report busy
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic logic is_busy(input state_e s);
    return (s == RUN) || (s == HOLD);
  endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// count_ctrl_if: command/status bundle between control logic and count_ctrl.
//   start  - request a run; only looked at while the sequencer is idle
//   stop   - abort the current run (wins over pause and stepping)
//   pause  - level; freezes the run for every cycle it is high
//   mode   - MODE_ONESHOT / MODE_PERIODIC, captured together with start
//   limit  - terminal count, captured together with start
//   count  - current count value (registered)
//   busy   - high while a run is active (RUN or HOLD)
//   tick   - one-cycle pulse following each terminal step
//   done   - one-cycle pulse when a one-shot run completes
// Command semantics: there is no valid/ready pairing. Every command is a
// level sampled on each rising clk edge; the sequencer never stalls the
// controller, it simply ignores commands that make no sense in its state
// (start outside IDLE, stop in IDLE). Status outputs change only on edges.
// master: the controller driving commands. slave: the count_ctrl sequencer.
interface count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output start, stop, pause, mode, limit,
    input  count, busy, tick, done
  );

  modport slave (
    input  start, stop, pause, mode, limit,
    output count, busy, tick, done
  );
endinterface

// File: rtl/count_core.sv
// count_core: WIDTH-bit synchronous up-counter datapath.
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force count to 0 (run aborted or finished)
//   reload    - force count to 0 after a periodic terminal step
//   en        - advance count by one
//   limit     - terminal value to compare against
//   count     - registered count value
//   terminal  - count equals limit (combinational from the register)
// The controller never asserts en at the terminal value, so the counter
// cannot wrap through 2^WIDTH-1 on its own.
module count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             reload,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (reload) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == limit);

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: start/stop/pause sequencer around a count_core counter.
// Supports one-shot and periodic (auto-reload) runs up to a terminal value
// captured at start; pulses tick after every terminal step and done when a
// one-shot run completes. All outputs are registered.
//   clk, rst   - clock, synchronous active-high reset
//   bus        - count_ctrl_if slave modport (commands in, status out)
//   fsm_state  - current sequencer state, for observation
// Build option: define CNT_CTRL_PRESCALE_EN to insert a 0..PRESCALE-1
// prescaler so that a count step happens only every PRESCALE active
// cycles. Without the macro, every unpaused RUN/HOLD cycle is a step and
// PRESCALE is ignored.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic   clk,
  input  logic   rst,
  count_ctrl_if.slave bus,
  output state_e fsm_state
);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             accept;    // start taken this cycle
  logic             advance;   // run active, not stopped, not paused
  logic             pre_wrap;  // prescaler at its last phase
  logic             step;      // counter moves this cycle
  logic             terminal;
  logic [WIDTH-1:0] count_val;
  logic             busy_q;
  logic             tick_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HOLD only records that the previous cycle was paused: any unpaused
  // edge in RUN or HOLD is an active cycle, so each paused cycle delays
  // the run by exactly one cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN, HOLD: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (bus.pause) begin
          state_next = HOLD;
        end else begin
          advance = 1'b1;
          step    = pre_wrap;
          if (step && terminal && (mode_q == MODE_ONESHOT)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
    end else if (accept) begin
      limit_q <= bus.limit;
      mode_q  <= bus.mode;
    end
  end

`ifdef CNT_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  // Counts active cycles; frozen while heading into HOLD, cleared on every
  // other path (start, stop, DONE, back to IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (advance) begin
      pre_q <= pre_wrap ? '0 : pre_q + PW'(1);
    end else if (state_next != HOLD) begin
      pre_q <= '0;
    end
  end

  assign pre_wrap = (pre_q == PRE_LAST);
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE > 0) && advance;
  assign pre_wrap        = 1'b1;
`endif

  count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_next == IDLE),
    .reload   (step && terminal && (mode_q == MODE_PERIODIC)),
    .en       (step && !terminal),
    .limit    (limit_q),
    .count    (count_val),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= is_busy(state_next);
      tick_q <= step && terminal;
      done_q <= step && terminal && (mode_q == MODE_ONESHOT);
    end
  end

  assign bus.count = count_val;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_count_ctrl.sv
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  localparam int W        = 4;
  localparam int PRESCALE = 4;
`ifdef CNT_CTRL_PRESCALE_EN
  localparam int P = PRESCALE;
`else
  localparam int P = 1;
`endif
  localparam int EW = W + 5;

  // ---------------- clock / reset ----------------
  logic   clk;
  logic   rst;
  state_e fsm_state;

  count_ctrl_if #(.WIDTH(W)) bus ();

  count_ctrl #(
    .WIDTH    (W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_err;

  // Reference model: tracks a run as "number of active cycles since start";
  // steps = act / P, and the count is the step number modulo (L+1).
  bit m_on;
  bit m_hold;
  bit m_in_done;
  bit m_tick;
  bit m_done;
  bit m_mode;
  int m_L;
  int m_act;
  int m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    m_tick = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_on      = 1'b0;
      m_hold    = 1'b0;
      m_in_done = 1'b0;
    end else if (m_in_done) begin
      m_in_done = 1'b0;
    end else if (!m_on) begin
      if (bus.start && !bus.stop) begin
        m_on   = 1'b1;
        m_hold = 1'b0;
        m_act  = 0;
        m_L    = int'(bus.limit);
        m_mode = bus.mode;
      end
    end else begin
      if (bus.stop) begin
        m_on   = 1'b0;
        m_hold = 1'b0;
      end else if (bus.pause) begin
        m_hold = 1'b1;
      end else begin
        m_hold = 1'b0;
        m_act++;
        if ((m_act % P) == 0 && ((m_act / P) % (m_L + 1)) == 0) begin
          m_tick = 1'b1;
          if (m_mode == MODE_ONESHOT) begin
            m_done    = 1'b1;
            m_on      = 1'b0;
            m_in_done = 1'b1;
          end
        end
      end
    end
    if (m_in_done)  m_count = m_L;
    else if (m_on)  m_count = (m_act / P) % (m_L + 1);
    else            m_count = 0;
  endtask

  function automatic logic [EW-1:0] model_pack();
    state_e s;
    if (m_in_done)  s = DONE;
    else if (m_on)  s = m_hold ? HOLD : RUN;
    else            s = IDLE;
    return {s, m_on, m_tick, m_done, W'(m_count)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s, input bit st, input bit p, input bit m, input int l);
    bus.start = s;
    bus.stop  = st;
    bus.pause = p;
    bus.mode  = m;
    bus.limit = W'(l);
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic cycle(input int n);
    logic [EW-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      exp_q.push_back(model_pack());
      #1;
      e = exp_q.pop_front();
      check("count", 32'(bus.count), 32'(e[W-1:0]));
      check("done",  32'(bus.done),  32'(e[W]));
      check("tick",  32'(bus.tick),  32'(e[W+1]));
      check("busy",  32'(bus.busy),  32'(e[W+2]));
      check("state", 32'(fsm_state), 32'(e[W+4:W+3]));
    end
  endtask

  task automatic start_run(input bit m, input int l);
    drive(1, 0, 0, m, l);
    cycle(1);
    idle_in();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    m_on = 0; m_hold = 0; m_in_done = 0; m_tick = 0; m_done = 0;
    m_mode = 0; m_L = 0; m_act = 0; m_count = 0;
    rst = 1'b1;
    idle_in();
    #1;
    cycle(2);
    rst = 1'b0;
    cycle(1);

    // one-shot L=3
    start_run(MODE_ONESHOT, 3);
    cycle(6 * P);

    // periodic L=15: full-range count, reload without overflow
    start_run(MODE_PERIODIC, 15);
    cycle(40 * P);
    drive(0, 1, 0, 0, 0);
    cycle(1);
    idle_in();
    cycle(2);

    // pause two cycles at count=1
    start_run(MODE_ONESHOT, 3);
    cycle(P);
    bus.pause = 1'b1;
    cycle(2);
    bus.pause = 1'b0;
    cycle(6 * P);

    // stop at count=2
    start_run(MODE_ONESHOT, 5);
    cycle(2 * P);
    drive(0, 1, 0, 0, 0);
    cycle(1);
    idle_in();
    cycle(2);

    // start and stop together in IDLE
    drive(1, 1, 0, 1, 2);
    cycle(2);
    idle_in();
    cycle(1);

    // start (with new limit/mode) during RUN is ignored
    start_run(MODE_PERIODIC, 4);
    drive(1, 0, 0, 0, 9);
    cycle(12 * P);
    drive(0, 1, 0, 0, 0);
    cycle(1);

    // start held through DONE: DONE ignores it, IDLE then accepts it
    drive(1, 0, 0, 0, 1);
    cycle(4 * P + 4);
    idle_in();
    cycle(6 * P);

    // rst while in HOLD
    start_run(MODE_ONESHOT, 5);
    cycle(2);
    bus.pause = 1'b1;
    cycle(2);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    idle_in();
    cycle(2);

    // limit=0 one-shot and periodic
    start_run(MODE_ONESHOT, 0);
    cycle(3 * P);
    start_run(MODE_PERIODIC, 0);
    cycle(5 * P);
    drive(0, 1, 0, 0, 0);
    cycle(1);

    // periodic L=1 (prescaled: count changes every PRESCALE cycles)
    start_run(MODE_PERIODIC, 1);
    cycle(20 * P);
    drive(0, 1, 0, 0, 0);
    cycle(1);
    idle_in();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.stop  = ($urandom_range(0, 29) == 0);
      bus.pause = ($urandom_range(0, 5) == 0);
      bus.mode  = 1'($urandom_range(0, 1));
      bus.limit = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, (1 << W) - 1))
                                              : W'($urandom_range(0, 3));
      cycle(1);
    end
    rst = 1'b0;
    idle_in();
    cycle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Synchronous sequencer for a WIDTH-bit count register, operated by start/stop/pause commands. It supports one-shot and periodic (auto-reload) runs up to a programmable terminal value. It produces a tick pulse on every terminal count and a done pulse when a one-shot run completes. It sits between control logic and the counter datapath and replaces free-running ripple counting with a controlled, single-clock counter.

## Interface
- WIDTH, 4: counter and limit width
- PRESCALE, 4: clocks per count step; only used when CNT_CTRL_PRESCALE_EN is defined; must be ≥1
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- stop  in  1  abort the run; return to IDLE
- pause  in  1  level; freezes the run while high
- mode  in  1  0 = one-shot, 1 = periodic; captured at start
- limit  in  WIDTH  terminal count; captured at start
- count  out  WIDTH  current count value (registered)
- busy  out  1  high in RUN and HOLD
- tick  out  1  one-cycle pulse per terminal step
- done  out  1  one-cycle pulse when a one-shot run completes

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset values: IDLE; count=0, busy=0, tick=0, done=0; captured limit/mode=0; prescaler=0.
- Command priority in every state: rst > stop > pause > count step. start is ignored outside IDLE.
- IDLE: count=0.
  - start=1 and stop=0: capture limit_q and mode_q, go to RUN with count=0.
  - start and stop together: stay in IDLE.
- RUN: on each step:
  - If count==limit_q (terminal step): tick=1 next cycle. One-shot goes to DONE with count held at limit_q. Periodic reloads count to 0 and stays in RUN.
  - Otherwise count+1.
  - Count never exceeds limit_q, so there is no wrap at 2^WIDTH-1; with limit=2^WIDTH-1 the next value is 0 via reload.
- RUN with pause=1: go to HOLD; no step in that cycle.
- HOLD: count frozen, busy=1. pause=0 returns to RUN; the next step happens on the following edge.
- stop in RUN or HOLD: next cycle is IDLE with count=0, busy=0, and no tick or done.
- DONE: lasts exactly one cycle, with done=1, tick=1, busy=0, count=limit_q; then IDLE (count=0). start in DONE is ignored.
- limit=0 is legal: one-shot completes after one step; periodic ticks on every step.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start sampled at edge E0 (without prescale):
  - After E0+k, count=k for 0≤k≤L.
  - Terminal step at edge E0+L+1: tick (and done for one-shot) high in the following cycle.
  - One-shot: IDLE after E0+L+2.
  - Periodic: tick period is L+1 cycles.
- Each HOLD cycle delays all subsequent events by one cycle.
- Reset asserted mid-run takes effect at the next edge, from any state.

## Configuration
- CNT_CTRL_PRESCALE_EN defined:
  - A 0..PRESCALE-1 prescaler runs only in RUN and is frozen in HOLD.
  - The prescaler clears on start, stop, rst and DONE.
  - A step occurs only when prescaler==PRESCALE-1, so the periodic tick period is (L+1)·PRESCALE.
- CNT_CTRL_PRESCALE_EN undefined: a step occurs every RUN cycle. The PRESCALE parameter is ignored and no prescaler register exists.

## Structure
- Package count_ctrl_pkg:
  - state typedef (IDLE, RUN, HOLD, DONE)
  - mode constants MODE_ONESHOT=1'b0 and MODE_PERIODIC=1'b1
- Sub-module count_core: WIDTH-bit synchronous counter with clear, reload and enable inputs and terminal-compare output. The FSM and prescaler stay in count_ctrl.

## Test plan
- One-shot, L=3, start at E0: count reads 0,1,2,3 after E0..E0+3; tick=done=1 for one cycle after E0+4; count=0 and busy=0 after E0+5.
- Periodic, L=15, WIDTH=4: count cycles 0..15 then 0 with no overflow; tick every 16 cycles; busy stays 1; done never asserts.
- Pause high for 2 cycles at count=1 (one-shot, L=3): count holds 1 through HOLD; done arrives 2 cycles later than without pause.
- Stop at count=2: next cycle count=0, busy=0, tick=done=0. Start and stop together in IDLE: remains IDLE. Start during RUN: ignored.
- rst asserted while in HOLD: next cycle all outputs 0, state IDLE. One-shot with limit=0: done after E0+1.
- CNT_CTRL_PRESCALE_EN with PRESCALE=4, periodic L=1: count changes every 4 cycles; tick every 8 cycles.
